alu_vec_arbiter: RTL
====================

# alu_vec_arbiter

Shares one `ALU_VECTORIAL` instance (`n_alu` lanes of `WIDTH` bits) between `N_REQ` requesters. A round-robin grant selects one request and registers its operands onto the ALU ports. After the ALU latency, the block captures the lane results and flags and returns them on a single response channel tagged with the requester index. It sits between the requester clients and the ALU. One operation is in flight at a time.

## Interface
- `WIDTH`, 4, lane width in bits
- `n_alu`, 4, number of ALU lanes
- `N_REQ`, 4, number of requesters (≥2)
- `SEL_W`, 3, ALU `select` width
- `ALU_LAT`, 1, ALU input-to-output latency in clocks (≥1)

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in `N_REQ`: per-requester request
- `req_ready` out `N_REQ`: one-hot grant/accept
- `req_a`, `req_b` in `N_REQ*n_alu*WIDTH`: packed operands; requester i at slice i
- `req_select` in `N_REQ*SEL_W`: packed op select
- `resp_valid` out 1: response available
- `resp_ready` in 1: response consumer ready
- `resp_id` out `$clog2(N_REQ)`: index of the requester that issued the op
- `resp_data` out `n_alu*WIDTH`: captured `data_out`
- `resp_flags` out `4*n_alu`: per lane {carry, greater, equal, less}
- `busy` out 1: state ≠ IDLE
- `alu_a`, `alu_b` out `n_alu*WIDTH`; `alu_select` out `SEL_W`: registered ALU inputs
- `alu_data_out` in `n_alu*WIDTH`; `alu_flags` in `4*n_alu`: ALU outputs

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, `req_ready[g]` = 1 combinationally for the winner g; all other `req_ready` bits are 0.
  - Accept occurs at the edge where `req_valid[g] & req_ready[g]`.
  - On accept: latch `req_a`/`req_b`/`req_select` slice g into the `alu_*` registers, store g, update the RR pointer to g, load the counter with `ALU_LAT`, go to EXEC.
- **EXEC**
  - `alu_*` held stable.
  - The counter decrements each cycle. The state lasts `ALU_LAT+1` cycles.
  - On the last cycle, capture `alu_data_out` and `alu_flags` into the response registers, then go to RESP.
- **RESP**
  - `resp_valid` = 1; `resp_id`, `resp_data` and `resp_flags` are stable until the handshake.
  - When `resp_valid & resp_ready`, go to IDLE.
  - `req_ready` = 0 throughout EXEC and RESP.
- **Round robin**
  - Search order starts at pointer+1, modulo `N_REQ`.
  - Pointer reset value is `N_REQ-1`, so requester 0 has first priority after reset.
  - The pointer changes only on accept.
- **Requester behaviour**
  - A requester whose `req_valid` drops before it is granted is simply not granted.
  - Operands are sampled only at the accept edge.
- **Widths:** the block performs no arithmetic on data; `resp_data` and `resp_flags` are passed bit-exact from the ALU.

## Timing
- Accept in cycle 0 → `alu_*` valid from cycle 1 → `resp_valid` in cycle `ALU_LAT+2` (cycle 3 for `ALU_LAT`=1).
- If `resp_ready` is already high, RESP lasts 1 cycle and IDLE follows in cycle `ALU_LAT+3`. Minimum issue interval is `ALU_LAT+3` cycles.
- **Backpressure:** RESP holds indefinitely while `resp_ready` = 0. No new grant is made during this time.
- **Reset**
  - Output values while `rst` = 0: all outputs 0 (`req_ready`, `resp_valid`, `resp_id`, `resp_data`, `resp_flags`, `busy`, `alu_a`, `alu_b`, `alu_select`).
  - State returns to IDLE, the counter is cleared and the pointer is set to `N_REQ-1`.
  - Reset mid-EXEC or mid-RESP drops the operation; no response is ever produced for it.
- **Same-cycle events:** a request arriving in the same cycle as the RESP handshake is not granted until the next (IDLE) cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Undefined (default): round-robin arbitration as above.
  - Defined: fixed priority, lowest asserted index wins. The pointer logic is removed. All other behaviour and timing are unchanged.

## Test plan
- The bench ALU model computes lane = (a+b) mod 2^WIDTH for `select`=0, with carry per lane and `ALU_LAT`=1.
- **Single request:** `req_valid[2]`=1, all lanes a=3, b=4, `select`=0, `resp_ready`=1 → `req_ready`=4'b0100 in cycle 0; `resp_valid`=1 in cycle 3 with `resp_id`=2, `resp_data`=16'h7777, `busy`=1 in cycles 1–3.
- **Round robin:** all 4 `req_valid` held high, `resp_ready`=1 → grant order 0,1,2,3,0 with accepts every 4 cycles.
- **Backpressure:** `resp_ready`=0 for 5 cycles during RESP → `resp_*` stable, `req_ready`=0; the next grant occurs only in the cycle after the handshake.
- **Carry:** lane 0 a=4'hF, b=4'h1 → `resp_data` lane 0 = 0, lane 0 carry flag = 1, other lanes unaffected.
- **Reset mid-op:** `rst` low during EXEC → all outputs 0 immediately, no `resp_valid` afterward; after release with requests 1 and 3 valid, requester 1 is granted first.
- **Fixed priority** (`ALU_ARB_FIXED_PRIO_EN` defined): requests 0 and 3 held valid → requester 0 granted every time; requester 3 is granted only after `req_valid[0]` drops.

Source files
------------

// File: rtl/alu_vec_arbiter.sv
// alu_vec_arbiter: shares one vector ALU between N_REQ requesters.
// A grant in IDLE registers the winner's operands onto the ALU ports; after
// ALU_LAT clocks the lane results and flags are captured and returned on a
// single response channel tagged with the requester index. One op in flight.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest
// asserted index wins) instead of round robin.
module alu_vec_arbiter #(
    parameter int WIDTH   = 4,
    parameter int n_alu   = 4,
    parameter int N_REQ   = 4,
    parameter int SEL_W   = 3,
    parameter int ALU_LAT = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [N_REQ-1:0]                i_req_valid,
    output logic [N_REQ-1:0]                o_req_ready,
    input  logic [N_REQ*n_alu*WIDTH-1:0]    i_req_a,
    input  logic [N_REQ*n_alu*WIDTH-1:0]    i_req_b,
    input  logic [N_REQ*SEL_W-1:0]          i_req_select,
    output logic                            o_resp_valid,
    input  logic                            i_resp_ready,
    output logic [$clog2(N_REQ)-1:0]        o_resp_id,
    output logic [n_alu*WIDTH-1:0]          o_resp_data,
    output logic [4*n_alu-1:0]              o_resp_flags,
    output logic                            o_busy,
    output logic [n_alu*WIDTH-1:0]          o_alu_a,
    output logic [n_alu*WIDTH-1:0]          o_alu_b,
    output logic [SEL_W-1:0]                o_alu_select,
    input  logic [n_alu*WIDTH-1:0]          i_alu_data_out,
    input  logic [4*n_alu-1:0]              i_alu_flags
);

    localparam int LANE_W = n_alu * WIDTH;
    localparam int ID_W   = $clog2(N_REQ);
    localparam int CNT_W  = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]    r_id;
    logic [LANE_W-1:0]  r_alu_a;
    logic [LANE_W-1:0]  r_alu_b;
    logic [SEL_W-1:0]   r_alu_select;
    logic [LANE_W-1:0]  r_resp_data;
    logic [4*n_alu-1:0] r_resp_flags;

    logic               w_grant_any;
    logic [ID_W-1:0]    w_grant_idx;
    logic [N_REQ-1:0]   w_grant_oh;
    logic               w_accept;
    logic               w_exec_done;
    logic [LANE_W-1:0]  w_sel_a;
    logic [LANE_W-1:0]  w_sel_b;
    logic [SEL_W-1:0]   w_sel_select;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: scanning downwards leaves the lowest asserted index.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_grant_idx = i_req_valid[i] ? ID_W'(i) : w_grant_idx;
            w_grant_any = w_grant_any | i_req_valid[i];
        end
    end
`else
    logic [ID_W-1:0] r_ptr;

    // Round robin: scan from ptr+N down to ptr+1 so the nearest index after ptr wins.
    always_comb begin
        int              v_pos;
        logic [ID_W-1:0] v_id;
        v_pos       = 0;
        v_id        = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            v_pos       = int'(r_ptr) + k;
            v_pos       = (v_pos >= N_REQ) ? (v_pos - N_REQ) : v_pos;
            v_id        = ID_W'(v_pos);
            w_grant_idx = i_req_valid[v_id] ? v_id : w_grant_idx;
            w_grant_any = w_grant_any | i_req_valid[v_id];
        end
    end

    // Pointer follows the last accepted requester; it moves only on accept.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ptr <= ID_W'(N_REQ - 1);
        end else if (w_accept) begin
            r_ptr <= w_grant_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    assign w_grant_oh  = w_grant_any ? (N_REQ'(1) << w_grant_idx) : '0;
    assign w_accept    = (r_state == ST_IDLE) && w_grant_any;
    assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == '0);

    // Operand mux selecting the granted requester's slices.
    always_comb begin
        w_sel_a      = '0;
        w_sel_b      = '0;
        w_sel_select = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sel_a      = (w_grant_idx == ID_W'(i)) ? i_req_a[i*LANE_W +: LANE_W] : w_sel_a;
            w_sel_b      = (w_grant_idx == ID_W'(i)) ? i_req_b[i*LANE_W +: LANE_W] : w_sel_b;
            w_sel_select = (w_grant_idx == ID_W'(i)) ? i_req_select[i*SEL_W +: SEL_W] : w_sel_select;
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_EXEC;
                else          w_state_nxt = ST_IDLE;
            end
            ST_EXEC: begin
                if (w_exec_done) w_state_nxt = ST_RESP;
                else             w_state_nxt = ST_EXEC;
            end
            ST_RESP: begin
                if (i_resp_ready) w_state_nxt = ST_IDLE;
                else              w_state_nxt = ST_RESP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Datapath: load ALU operands on accept, count latency, capture results.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt        <= '0;
            r_id         <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_select <= '0;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_a      <= w_sel_a;
                        r_alu_b      <= w_sel_b;
                        r_alu_select <= w_sel_select;
                        r_id         <= w_grant_idx;
                        r_cnt        <= CNT_W'(ALU_LAT);
                    end else begin
                        r_cnt        <= r_cnt;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == '0) begin
                        r_resp_data  <= i_alu_data_out;
                        r_resp_flags <= i_alu_flags;
                    end else begin
                        r_cnt        <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Grant is combinational in IDLE and forced low while reset is asserted.
    assign o_req_ready  = (i_rst && (r_state == ST_IDLE)) ? w_grant_oh : '0;
    assign o_resp_valid = (r_state == ST_RESP);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_resp_id    = r_id;
    assign o_resp_data  = r_resp_data;
    assign o_resp_flags = r_resp_flags;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_select = r_alu_select;

endmodule
